behavioural_cache: RTL and testbench
====================================

Name: behavioural_cache

Overview:
Behavioural unified instruction/data memory, presented as a cache, that serves the CPU core in the top-level simulation entry.
- One shared backing array: `imem`, 32-bit words, hierarchically visible so ROMs can be preloaded with $readmemh.
- Two independent ports: a 32-bit instruction-fetch port and a FETCH_WIDTH data read/write port.
- Each port has a fixed-latency busy/ready handshake.

Parameters:
- DATA_WIDTH, 64, address width of both ports (byte addresses).
- FETCH_WIDTH, 64, data-port width in bits; must be a multiple of 32.
- MEM_WORDS, 65536, depth of `imem` in 32-bit words (256 KiB).
- LATENCY, 1, cycles from request acceptance to the ready pulse; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dmem_rd_en_i  in  1  data read request.
- imem_rd_en_i  in  1  instruction fetch request.
- dmem_wr_en_i  in  1  data write request.
- dmem_addr_i  in  DATA_WIDTH  data byte address.
- imem_addr_i  in  DATA_WIDTH  fetch byte address.
- dmem_wr_size_i  in  $clog2(FETCH_WIDTH/8)  write size as log2 of the byte count: 0=1B, 1=2B, 2=4B, 3=8B.
- dmem_wr_data_i  in  FETCH_WIDTH  write data, LSB-aligned.
- dmem_busy_o  out  1  data request outstanding.
- imem_busy_o  out  1  fetch outstanding.
- dmem_rdy_o  out  1  one-cycle completion pulse for a data read or write.
- imem_rdy_o  out  1  one-cycle fetch completion pulse.
- dmem_rd_data_o  out  FETCH_WIDTH  read data, LSB = byte at the address.
- imem_rd_data_o  out  32  fetched instruction word.

Behaviour:
- Memory organisation:
  - Byte-addressed and little-endian over `imem`.
  - Byte b lives in word (b>>2) mod MEM_WORDS, bits 8*(b&3)+:8.
  - Addresses wrap modulo MEM_WORDS*4.
  - The array is never cleared by reset and has no reset value.
- Per-port state machine, IDLE -> WAIT:
  - In IDLE with busy=0, a request is accepted: address, size and data are latched, busy goes to 1, and a counter loads LATENCY-1.
  - In WAIT, the counter decrements.
  - When the counter reaches 0: the read is performed, the result is driven on rd_data, rdy pulses for exactly 1 cycle, busy returns to 0, and the port goes back to IDLE.
  - The next request can be accepted in the cycle after rdy.
  - Requests presented while busy=1 are ignored. The requester must hold them until busy=0.
- Latency: with LATENCY=1, a request at clock edge N gives rdy and data valid after edge N+1.
- Fetch port:
  - Returns the aligned word at imem_addr_i>>2.
  - Low 2 address bits are ignored.
- Data read:
  - Returns FETCH_WIDTH/8 consecutive bytes starting at dmem_addr_i.
  - Unaligned access is allowed, including across the array end (wraps).
- Data write:
  - Writes 2^size bytes from the low bytes of wr_data at dmem_addr_i.
  - Sizes above log2(FETCH_WIDTH/8) are ignored: no memory change, but rdy still pulses.
  - The write is committed to the array on the rdy cycle.
- Simultaneous dmem_rd_en_i and dmem_wr_en_i: the write wins and the read is dropped. dmem_rd_data_o keeps its previous value.
- Fetch and data completing in the same cycle on the same word: the fetch returns the pre-write contents (read-before-write).
- rd_data outputs hold their last value between completions.
- Reset:
  - All busy and rdy outputs go to 0, both rd_data outputs go to 0, and both ports return to IDLE.
  - Reset asserted mid-operation abandons the request: no pending write is committed and no rdy pulse follows.

Decomposition:
- Shared package `mem_pkg` holds:
  - the size encoding constants (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3);
  - the port state enum {IDLE, WAIT}.
- One natural sub-module, `mem_port_ctrl`: the busy/rdy/latency counter FSM, instantiated once per port.
- The top holds the array and the byte read/write logic.

Test Plan:
- Preload word 0 = 0x00000013, word 16384 = 0xDEADBEEF. Fetch at address 0x0, then at 0x10000 -> imem_rdy_o pulses 1 cycle after each request; data 0x00000013, then 0xDEADBEEF.
- Write size 3, data 0x1122334455667788 at 0x100, then read 0x100 -> 0x1122334455667788. Then fetch 0x104 -> 0x11223344.
- Write size 0, data 0xAB at 0x101 over the previous word, then read 0x100 -> 0x112233445566AB88. Size 1 at 0x102 with 0xCDEF -> 0x11223344CDEFAB88.
- Unaligned read at 0x3FFFC with words 0xFFFF = 0xAAAAAAAA and 0 = 0x00000013 -> 0x00000013AAAAAAAA.
- Issue a second request while busy=1 -> ignored, exactly one rdy pulse. Request plus reset on the next cycle -> no rdy, memory unchanged, all outputs 0.
- Simultaneous rd+wr at 0x200 with data 0x5 size 2 -> word 128 = 0x5, dmem_rd_data_o unchanged, single rdy.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the behavioural cache: data-port write size
// encodings and the per-port handshake state.
package mem_pkg;

  // Write size codes are log2 of the byte count.
  localparam int SZ_B = 0;
  localparam int SZ_H = 1;
  localparam int SZ_W = 2;
  localparam int SZ_D = 3;

  // A port is either free to accept a request or counting down to completion.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } port_state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// Fixed-latency request controller for one memory port.
//
// Handshake: while state_o == IDLE (busy low) a high req_i is accepted at the
// clock edge (accept_o high in that cycle). Exactly LATENCY edges later the
// access completes: done_o is high in the cycle before that edge, and rdy_o is
// a registered one-cycle pulse after it. Requests seen while in WAIT are
// ignored; the requester holds its request until busy is low again.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        accept_o,
  output logic        done_o,
  output logic        rdy_o,
  output port_state_e state_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  port_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  // State, latency counter and completion pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Accept in IDLE, count down in WAIT, complete when the counter hits zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b0;
    accept_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept_o = 1'b1;
          cnt_d    = CW'(LATENCY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_o   = rdy_q;
  assign state_o = state_q;

endmodule

// File: rtl/behavioural_cache.sv
// Behavioural unified instruction/data memory with two fixed-latency ports.
// The backing array `imem` is byte-addressed little-endian over 32-bit words
// and is left unreset so it can be preloaded hierarchically. MEM_WORDS is
// expected to be a power of two so address wrap reduces to bit truncation.
module behavioural_cache
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  parameter int MEM_WORDS   = 65536,
  parameter int LATENCY     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dmem_rd_en_i,
  input  logic                               imem_rd_en_i,
  input  logic                               dmem_wr_en_i,
  input  logic [DATA_WIDTH-1:0]              dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]              imem_addr_i,
  input  logic [$clog2(FETCH_WIDTH/8)-1:0]   dmem_wr_size_i,
  input  logic [FETCH_WIDTH-1:0]             dmem_wr_data_i,
  output logic                               dmem_busy_o,
  output logic                               imem_busy_o,
  output logic                               dmem_rdy_o,
  output logic                               imem_rdy_o,
  output logic [FETCH_WIDTH-1:0]             dmem_rd_data_o,
  output logic [31:0]                        imem_rd_data_o
);

  localparam int NBYTES = FETCH_WIDTH / 8;
  localparam int SW     = $clog2(NBYTES);
  localparam int MAX_SZ = SW;
  localparam int WI_W   = $clog2(MEM_WORDS);

  logic [31:0] imem [MEM_WORDS];

  // Word index holding byte address b, wrapping over the array.
  function automatic logic [WI_W-1:0] word_of(input logic [DATA_WIDTH-1:0] b);
    return WI_W'((b >> 2) % DATA_WIDTH'(MEM_WORDS));
  endfunction

  // Bit offset of byte address b inside its word.
  function automatic int lane_of(input logic [DATA_WIDTH-1:0] b);
    return int'(b & DATA_WIDTH'(3)) * 8;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [DATA_WIDTH-1:0] b);
    return imem[word_of(b)][lane_of(b) +: 8];
  endfunction

  port_state_e d_state, i_state;
  logic        d_accept, d_done, i_accept, i_done;

  logic [DATA_WIDTH-1:0]  d_addr_q;
  logic [SW-1:0]          d_size_q;
  logic [FETCH_WIDTH-1:0] d_wdata_q;
  logic                   d_is_wr_q;
  logic [DATA_WIDTH-1:0]  i_addr_q;
  logic [FETCH_WIDTH-1:0] d_rd_data_q, d_rd_data_d;
  logic [31:0]            i_rd_data_q, i_rd_data_d;

  mem_port_ctrl #(.LATENCY(LATENCY)) u_dctrl (
    .clk      (clk),
    .rst      (rst),
    .req_i    (dmem_rd_en_i | dmem_wr_en_i),
    .accept_o (d_accept),
    .done_o   (d_done),
    .rdy_o    (dmem_rdy_o),
    .state_o  (d_state)
  );

  mem_port_ctrl #(.LATENCY(LATENCY)) u_ictrl (
    .clk      (clk),
    .rst      (rst),
    .req_i    (imem_rd_en_i),
    .accept_o (i_accept),
    .done_o   (i_done),
    .rdy_o    (imem_rdy_o),
    .state_o  (i_state)
  );

  assign dmem_busy_o = (d_state == WAIT);
  assign imem_busy_o = (i_state == WAIT);

  // Gather the unaligned, possibly wrapping, data-port read bytes.
  always_comb begin
    d_rd_data_d = '0;
    for (int k = 0; k < NBYTES; k++) begin
      d_rd_data_d[8*k +: 8] = mem_byte(d_addr_q + DATA_WIDTH'(k));
    end
  end

  // Fetch ignores the low address bits and returns the whole word.
  always_comb begin
    i_rd_data_d = imem[word_of(i_addr_q)];
  end

  // Request latches and the held read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_addr_q    <= '0;
      d_size_q    <= '0;
      d_wdata_q   <= '0;
      d_is_wr_q   <= 1'b0;
      i_addr_q    <= '0;
      d_rd_data_q <= '0;
      i_rd_data_q <= '0;
    end else begin
      if (d_accept) begin
        d_addr_q  <= dmem_addr_i;
        d_size_q  <= dmem_wr_size_i;
        d_wdata_q <= dmem_wr_data_i;
        // A simultaneous read is dropped in favour of the write.
        d_is_wr_q <= dmem_wr_en_i;
      end
      if (i_accept) begin
        i_addr_q <= imem_addr_i;
      end
      if (d_done && !d_is_wr_q) begin
        d_rd_data_q <= d_rd_data_d;
      end
      if (i_done) begin
        i_rd_data_q <= i_rd_data_d;
      end
    end
  end

  // Commit writes on the completion edge; fetch reads the old contents via NBA.
  always_ff @(posedge clk) begin
    if (!rst && d_done && d_is_wr_q && (int'(d_size_q) <= MAX_SZ)) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (k < (1 << d_size_q)) begin
          imem[word_of(d_addr_q + DATA_WIDTH'(k))][lane_of(d_addr_q + DATA_WIDTH'(k)) +: 8]
            <= d_wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign dmem_rd_data_o = d_rd_data_q;
  assign imem_rd_data_o = i_rd_data_q;

endmodule

// File: tb/tb_behavioural_cache.sv
// Bench for behavioural_cache: directed cases plus randomized traffic checked
// against a byte-array reference model through per-port expectation queues.
module tb_behavioural_cache;

  localparam int          MEM_WORDS = 65536;
  localparam longint      MEM_BYTES = 64'(MEM_WORDS) * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_rd_en_i = 1'b0;
  logic        imem_rd_en_i = 1'b0;
  logic        dmem_wr_en_i = 1'b0;
  logic [63:0] dmem_addr_i = '0;
  logic [63:0] imem_addr_i = '0;
  logic [2:0]  dmem_wr_size_i = '0;
  logic [63:0] dmem_wr_data_i = '0;
  logic        dmem_busy_o, imem_busy_o, dmem_rdy_o, imem_rdy_o;
  logic [63:0] dmem_rd_data_o;
  logic [31:0] imem_rd_data_o;

  behavioural_cache dut (
    .clk            (clk),
    .rst            (rst),
    .dmem_rd_en_i   (dmem_rd_en_i),
    .imem_rd_en_i   (imem_rd_en_i),
    .dmem_wr_en_i   (dmem_wr_en_i),
    .dmem_addr_i    (dmem_addr_i),
    .imem_addr_i    (imem_addr_i),
    .dmem_wr_size_i (dmem_wr_size_i),
    .dmem_wr_data_i (dmem_wr_data_i),
    .dmem_busy_o    (dmem_busy_o),
    .imem_busy_o    (imem_busy_o),
    .dmem_rdy_o     (dmem_rdy_o),
    .imem_rdy_o     (imem_rdy_o),
    .dmem_rd_data_o (dmem_rd_data_o),
    .imem_rd_data_o (imem_rd_data_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mb [MEM_BYTES];
  logic [63:0] last_d = '0;
  logic [31:0] last_i = '0;
  logic [63:0] exp_d_q [$];
  logic [31:0] exp_i_q [$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mb[(a + 64'(k)) % MEM_BYTES];
    return r;
  endfunction

  function automatic logic [31:0] m_fetch(input logic [63:0] a);
    logic [31:0] r;
    logic [63:0] base;
    base = (a & ~64'h3) % MEM_BYTES;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mb[base + 64'(k)];
    return r;
  endfunction

  function automatic void m_write(input logic [63:0] a, input logic [2:0] sz, input logic [63:0] d);
    if (sz <= 3'd3) begin
      for (int k = 0; k < (1 << sz); k++) mb[(a + 64'(k)) % MEM_BYTES] = d[8*k +: 8];
    end
  endfunction

  task automatic preload(input int w, input logic [31:0] v);
    dut.imem[w] = v;
    for (int j = 0; j < 4; j++) mb[4*w + j] = v[8*j +: 8];
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_rdy_o) begin
        if (exp_d_q.size() == 0) chk("d_unexpected_rdy", 64'(dmem_rdy_o), 64'd0);
        else chk("d_rd_data", dmem_rd_data_o, exp_d_q.pop_front());
      end
      if (imem_rdy_o) begin
        if (exp_i_q.size() == 0) chk("i_unexpected_rdy", 64'(imem_rdy_o), 64'd0);
        else chk("i_rd_data", 64'(imem_rd_data_o), 64'(exp_i_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues a fetch and/or a data access in the same cycle and checks timing.
  task automatic issue(input bit do_i, input logic [63:0] ia, input bit rd, input bit wr,
                       input logic [63:0] da, input logic [2:0] sz, input logic [63:0] wd);
    bit do_d;
    do_d = rd | wr;
    if (do_i) begin
      last_i = m_fetch(ia);  // sampled before any same-cycle write
      exp_i_q.push_back(last_i);
    end
    if (do_d) begin
      if (wr) m_write(da, sz, wd);
      else    last_d = m_read(da);
      exp_d_q.push_back(last_d);
    end
    imem_rd_en_i = do_i; imem_addr_i = ia;
    dmem_rd_en_i = rd; dmem_wr_en_i = wr; dmem_addr_i = da;
    dmem_wr_size_i = sz; dmem_wr_data_i = wd;
    @(posedge clk); #1;
    imem_rd_en_i = 1'b0; dmem_rd_en_i = 1'b0; dmem_wr_en_i = 1'b0;
    if (do_i) chk("i_busy_after_accept", 64'(imem_busy_o), 64'd1);
    if (do_d) chk("d_busy_after_accept", 64'(dmem_busy_o), 64'd1);
    @(posedge clk); #1;
    if (do_i) begin
      chk("i_rdy_latency", 64'(imem_rdy_o), 64'd1);
      chk("i_busy_clear", 64'(imem_busy_o), 64'd0);
    end
    if (do_d) begin
      chk("d_rdy_latency", 64'(dmem_rdy_o), 64'd1);
      chk("d_busy_clear", 64'(dmem_busy_o), 64'd0);
    end
    @(posedge clk); #1;
    if (do_i) chk("i_rdy_one_cycle", 64'(imem_rdy_o), 64'd0);
    if (do_d) chk("d_rdy_one_cycle", 64'(dmem_rdy_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a, ia, wd;
    logic [31:0] w;
    int kind;

    for (int i = 0; i < MEM_WORDS; i++) begin
      w = $urandom;
      preload(i, w);
    end
    preload(0, 32'h0000_0013);
    preload(16384, 32'hDEAD_BEEF);
    preload(16'hFFFF, 32'hAAAA_AAAA);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_d_busy", 64'(dmem_busy_o), 64'd0);
    chk("reset_i_busy", 64'(imem_busy_o), 64'd0);
    chk("reset_d_rdy", 64'(dmem_rdy_o), 64'd0);
    chk("reset_i_rdy", 64'(imem_rdy_o), 64'd0);
    chk("reset_d_data", dmem_rd_data_o, 64'd0);
    chk("reset_i_data", 64'(imem_rd_data_o), 64'd0);

    // Preloaded fetches.
    issue(1, 64'h0, 0, 0, 0, 0, 0);
    issue(1, 64'h10000, 0, 0, 0, 0, 0);
    // Double-word write, read back, fetch upper half.
    issue(0, 0, 0, 1, 64'h100, 3'd3, 64'h1122334455667788);
    issue(0, 0, 1, 0, 64'h100, 0, 0);
    issue(1, 64'h104, 0, 0, 0, 0, 0);
    // Byte and halfword merges.
    issue(0, 0, 0, 1, 64'h101, 3'd0, 64'hAB);
    issue(0, 0, 1, 0, 64'h100, 0, 0);
    issue(0, 0, 0, 1, 64'h102, 3'd1, 64'hCDEF);
    issue(0, 0, 1, 0, 64'h100, 0, 0);
    chk("merge_model_sanity", m_read(64'h100), 64'h11223344CDEFAB88);
    // Unaligned read across the end of the array.
    issue(0, 0, 1, 0, 64'h3FFFC, 0, 0);
    chk("wrap_model_sanity", last_d, 64'h00000013AAAAAAAA);

    // Second request while busy is ignored: one rdy, no write to 0x300.
    last_d = m_read(64'h100);
    exp_d_q.push_back(last_d);
    dmem_rd_en_i = 1'b1; dmem_addr_i = 64'h100;
    @(posedge clk); #1;
    dmem_rd_en_i = 1'b0; dmem_wr_en_i = 1'b1; dmem_addr_i = 64'h300;
    dmem_wr_size_i = 3'd3; dmem_wr_data_i = 64'hFEED_FACE_CAFE_F00D;
    @(posedge clk); #1;
    chk("busy_ignore_rdy", 64'(dmem_rdy_o), 64'd1);
    dmem_wr_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 0, 1, 0, 64'h300, 0, 0);

    // Reset mid-operation abandons the write.
    dmem_wr_en_i = 1'b1; dmem_addr_i = 64'h400; dmem_wr_size_i = 3'd3;
    dmem_wr_data_i = 64'h0123_4567_89AB_CDEF;
    imem_rd_en_i = 1'b1; imem_addr_i = 64'h400;
    @(posedge clk); #1;
    rst = 1'b1; dmem_wr_en_i = 1'b0; imem_rd_en_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_d_busy", 64'(dmem_busy_o), 64'd0);
    chk("midrst_i_busy", 64'(imem_busy_o), 64'd0);
    chk("midrst_d_rdy", 64'(dmem_rdy_o), 64'd0);
    chk("midrst_i_rdy", 64'(imem_rdy_o), 64'd0);
    chk("midrst_d_data", dmem_rd_data_o, 64'd0);
    chk("midrst_i_data", 64'(imem_rd_data_o), 64'd0);
    last_d = '0; last_i = '0;
    repeat (2) @(posedge clk);
    #1;
    issue(0, 0, 1, 0, 64'h400, 0, 0);

    // Simultaneous read and write: write wins, read data held.
    issue(0, 0, 1, 1, 64'h200, 3'd2, 64'h5);
    issue(1, 64'h200, 0, 0, 0, 0, 0);
    chk("rdwr_word128", 64'(last_i), 64'h5);
    // Fetch and write completing together on one word: fetch sees old data.
    issue(1, 64'h202, 0, 1, 64'h200, 3'd2, 64'h7777_8888);
    issue(1, 64'h200, 0, 0, 0, 0, 0);
    // Oversized write is ignored but still completes.
    issue(0, 0, 0, 1, 64'h200, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(0, 0, 1, 0, 64'h200, 0, 0);

    // Randomized traffic over a small window and the wrap region.
    for (int n = 0; n < 300; n++) begin
      a  = {32'($urandom), 32'(($urandom_range(0, 1) != 0) ? 32'h3FFF0 : 32'h1000)
            + 32'($urandom_range(0, 31))};
      ia = ($urandom_range(0, 3) == 0) ? a : {32'($urandom), 32'h1000 + 32'($urandom_range(0, 31))};
      wd = {$urandom, $urandom};
      kind = $urandom_range(0, 4);
      issue(($urandom_range(0, 1) != 0) || (kind == 0), ia,
            (kind == 1) || (kind == 3), (kind >= 2), a, 3'($urandom_range(0, 7)), wd);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("d_queue_drained", 64'(exp_d_q.size()), 64'd0);
    chk("i_queue_drained", 64'(exp_i_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
